// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // ALU control encodings (forwarded untouched; 3'b111 is left to the ALU)
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLLI = 3'b110;

    // Largest requester count the slice is built for
    localparam int MAX_REQ = 4;

    // Grant-index width: clog2 of the requester count, never below one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Grant index wide enough for any supported requester count
    typedef logic [idx_w(MAX_REQ)-1:0] grant_idx_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               hit
);

    // Scan NUM_REQ slots starting at ptr; the first valid slot wins
    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        c   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            c = (int'(ptr) + off) % NUM_REQ;
            if (!hit && valid[c]) begin
                hit    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one single-cycle ALU between NUM_REQ requesters.
// One operation in flight: accept (IDLE) -> drive ALU (EXEC) -> hold result (RESP).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   ReqValid_i,
    output logic [NUM_REQ-1:0]                   ReqReady_o,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   ReqSrcA_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   ReqSrcB_i,
    input  logic [NUM_REQ-1:0][2:0]              ReqOp_i,
    output logic [NUM_REQ-1:0]                   RspValid_o,
    input  logic [NUM_REQ-1:0]                   RspReady_i,
    output logic [DATA_WIDTH-1:0]                RspResult_o,
    output logic                                 RspZero_o,
    output logic [DATA_WIDTH-1:0]                AluSrcA_o,
    output logic [DATA_WIDTH-1:0]                AluSrcB_o,
    output logic [2:0]                           AluControl_o,
    input  logic [DATA_WIDTH-1:0]                AluResult_i,
    input  logic                                 AluZero_i,
    output logic                                 Busy_o
);

    localparam int IDX_W = idx_w(NUM_REQ);

    typedef logic [IDX_W-1:0] gidx_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] src_a;
        logic [DATA_WIDTH-1:0] src_b;
        logic [2:0]            op;
    } alu_req_t;

    arb_state_e            state_q, state_d;
    gidx_t                 ptr_q, own_q, arb_idx;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic                  arb_hit;
    alu_req_t              req_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  accept;
    logic                  rsp_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid (ReqValid_i),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .hit   (arb_hit)
    );

    // Only the owner's ready can retire the response
    assign rsp_done = (state_q == RESP) && RspReady_i[own_q];

    // Next state plus handshake outputs; ready is masked while reset is held
    always_comb begin
        state_d    = state_q;
        ReqReady_o = '0;
        RspValid_o = '0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_hit && !rst_i) begin
                    ReqReady_o = arb_gnt;
                    accept     = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                RspValid_o[own_q] = 1'b1;
                if (rsp_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Latched request, owner, captured result and the fairness pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q    <= '0;
            own_q    <= '0;
            ptr_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_q.src_a <= ReqSrcA_i[arb_idx];
                req_q.src_b <= ReqSrcB_i[arb_idx];
                req_q.op    <= ReqOp_i[arb_idx];
                own_q       <= arb_idx;
            end
            if (state_q == EXEC) begin
                result_q <= AluResult_i;
                zero_q   <= AluZero_i;
            end
            // pointer moves only when the response is actually taken
            if (rsp_done)
                ptr_q <= (own_q == gidx_t'(NUM_REQ-1)) ? '0 : own_q + gidx_t'(1);
        end
    end

    assign AluSrcA_o    = req_q.src_a;
    assign AluSrcB_o    = req_q.src_b;
    assign AluControl_o = req_q.op;
    assign RspResult_o  = result_q;
    assign RspZero_o    = zero_q;
    assign Busy_o       = (state_q != IDLE);

endmodule
